// File: rtl/uart_pkg.sv
// uart_pkg: state enums and legal parameter bounds shared by uart_core
// RX_PARITY/TX_PARITY exist only when UART_PARITY_EN is defined
package uart_pkg;
    localparam int MIN_DATA_BITS = 5;
    localparam int MAX_DATA_BITS = 9;
    localparam int MIN_STOP_BITS = 1;
    localparam int MAX_STOP_BITS = 2;
    localparam int CNT_BITS      = $clog2(MAX_DATA_BITS + 1);
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef UART_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP
    } rx_state_t;
    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
`ifdef UART_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } tx_state_t;
endpackage

// File: rtl/uart_baud_timer.sv
// uart_baud_timer: loadable baud down-counter, ticks at 0 and reloads divisor-1
// A load latches the divisor and starts from divisor/2 (i_half) or divisor-1
module uart_baud_timer #(
    parameter int TIMER_BITS = 10
) (
    input  logic                  clk,
    input  logic                  i_reset,
    input  logic                  i_load,
    input  logic                  i_half,
    input  logic [TIMER_BITS-1:0] i_div,
    output logic                  o_tick
);
    logic [TIMER_BITS-1:0] div, cnt;
    always_ff @(posedge clk) begin
        if (i_reset) begin
            div <= '0;
            cnt <= '0;
        end else if (i_load) begin
            div <= i_div;
            cnt <= i_half ? i_div >> 1 : i_div - 1'b1;
        end else begin
            cnt <= (cnt == '0) ? div - 1'b1 : cnt - 1'b1;
        end
    end
    assign o_tick = cnt == '0;
endmodule

// File: rtl/uart_core.sv
// uart_core: full-duplex UART with valid/ready byte channels and a runtime baud divisor
// Define UART_PARITY_EN to add a parity bit (odd when PARITY_ODD=1) in both directions
module uart_core
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int TIMER_BITS = 10,
    parameter int PARITY_ODD = 0
) (
    input  logic                  clk,
    input  logic                  i_reset,
    input  logic [TIMER_BITS-1:0] i_clks_per_baud,
    input  logic                  i_rx,
    output logic                  o_tx,
    input  logic [DATA_BITS-1:0]  i_tx_data,
    input  logic                  i_tx_valid,
    output logic                  o_tx_ready,
    output logic [DATA_BITS-1:0]  o_rx_data,
    output logic                  o_rx_valid,
    input  logic                  i_rx_ready,
    output logic                  o_rx_frame_err,
    output logic                  o_rx_parity_err,
    output logic                  o_rx_overrun
);
    localparam logic [CNT_BITS-1:0] LAST_DATA = CNT_BITS'(DATA_BITS - 1);
    localparam logic [CNT_BITS-1:0] LAST_STOP = CNT_BITS'(STOP_BITS - 1);
    if (DATA_BITS < MIN_DATA_BITS || DATA_BITS > MAX_DATA_BITS || STOP_BITS < MIN_STOP_BITS ||
        STOP_BITS > MAX_STOP_BITS || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
        $error("uart_core: illegal DATA_BITS, STOP_BITS or PARITY_ODD");
    end
    rx_state_t rx_state;
    tx_state_t tx_state;
    logic rx_s1, rx_s2, rx_s3, rx_fall, rx_tick, tx_tick, tx_go, tx_post;
    logic [CNT_BITS-1:0] rx_n, tx_n;
    logic [DATA_BITS-1:0] rx_sh, tx_sh;
`ifdef UART_PARITY_EN
    localparam rx_state_t RX_AFTER_DATA = RX_PARITY;
    localparam tx_state_t TX_AFTER_DATA = TX_PARITY;
    logic tx_par, rx_par;
    assign tx_post = tx_par;
`else
    localparam rx_state_t RX_AFTER_DATA = RX_STOP;
    localparam tx_state_t TX_AFTER_DATA = TX_STOP;
    assign tx_post = 1'b1;
    assign o_rx_parity_err = 1'b0;
`endif
    assign rx_fall = rx_state == RX_IDLE && rx_s3 && !rx_s2;
    // ready during the last clock of the final stop bit allows gapless back-to-back frames
    assign o_tx_ready = tx_state == TX_IDLE || (tx_state == TX_STOP && tx_n == LAST_STOP && tx_tick);
    assign tx_go = i_tx_valid && o_tx_ready;
    uart_baud_timer #(.TIMER_BITS(TIMER_BITS)) u_rx_timer (
        .clk(clk), .i_reset(i_reset), .i_load(rx_fall), .i_half(1'b1),
        .i_div(i_clks_per_baud), .o_tick(rx_tick)
    );
    uart_baud_timer #(.TIMER_BITS(TIMER_BITS)) u_tx_timer (
        .clk(clk), .i_reset(i_reset), .i_load(tx_go), .i_half(1'b0),
        .i_div(i_clks_per_baud), .o_tick(tx_tick)
    );
    always_ff @(posedge clk) begin
        if (i_reset) begin
            {rx_s3, rx_s2, rx_s1} <= 3'b111;
            rx_state       <= RX_IDLE;
            rx_n           <= '0;
            rx_sh          <= '0;
            o_rx_data      <= '0;
            o_rx_valid     <= 1'b0;
            o_rx_frame_err <= 1'b0;
            o_rx_overrun   <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par          <= 1'b0;
            o_rx_parity_err <= 1'b0;
`endif
        end else begin
            {rx_s3, rx_s2, rx_s1} <= {rx_s2, rx_s1, i_rx};
            o_rx_overrun <= 1'b0;
            if (o_rx_valid && i_rx_ready) o_rx_valid <= 1'b0;
            case (rx_state)
                RX_IDLE: if (rx_fall) rx_state <= RX_START;
                RX_START: if (rx_tick) begin
                    rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                    rx_n     <= '0;
                end
                RX_DATA: if (rx_tick) begin
                    rx_sh <= {rx_s2, rx_sh[DATA_BITS-1:1]};
                    rx_n  <= rx_n + 1'b1;
                    if (rx_n == LAST_DATA) rx_state <= RX_AFTER_DATA;
                end
`ifdef UART_PARITY_EN
                RX_PARITY: if (rx_tick) begin
                    rx_par   <= (^rx_sh ^ rx_s2) != 1'(PARITY_ODD);
                    rx_state <= RX_STOP;
                end
`endif
                RX_STOP: if (rx_tick) begin
                    rx_state <= RX_IDLE;
                    if (!o_rx_valid || i_rx_ready) begin
                        o_rx_data      <= rx_sh;
                        o_rx_valid     <= 1'b1;
                        o_rx_frame_err <= !rx_s2;
`ifdef UART_PARITY_EN
                        o_rx_parity_err <= rx_par;
`endif
                    end else begin
                        o_rx_overrun <= 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (i_reset) begin
            tx_state <= TX_IDLE;
            o_tx     <= 1'b1;
            tx_n     <= '0;
            tx_sh    <= '0;
`ifdef UART_PARITY_EN
            tx_par <= 1'b0;
`endif
        end else if (tx_go) begin
            tx_state <= TX_START;
            o_tx     <= 1'b0;
            tx_sh    <= i_tx_data;
`ifdef UART_PARITY_EN
            tx_par <= ^i_tx_data ^ 1'(PARITY_ODD);
`endif
        end else if (tx_tick) begin
            case (tx_state)
                TX_START: begin
                    tx_state <= TX_DATA;
                    o_tx     <= tx_sh[0];
                    tx_sh    <= tx_sh >> 1;
                    tx_n     <= '0;
                end
                TX_DATA: begin
                    o_tx  <= (tx_n == LAST_DATA) ? tx_post : tx_sh[0];
                    tx_sh <= tx_sh >> 1;
                    tx_n  <= (tx_n == LAST_DATA) ? '0 : tx_n + 1'b1;
                    if (tx_n == LAST_DATA) tx_state <= TX_AFTER_DATA;
                end
`ifdef UART_PARITY_EN
                TX_PARITY: begin
                    tx_state <= TX_STOP;
                    o_tx     <= 1'b1;
                    tx_n     <= '0;
                end
`endif
                TX_STOP: begin
                    tx_n <= tx_n + 1'b1;
                    if (tx_n == LAST_STOP) tx_state <= TX_IDLE;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: table vectors, hand sequences and random loopback checked against a frame-level model
module tb_uart_core;
    localparam int DB = 8;
    localparam int SB = 1;
    localparam int TB = 10;
`ifdef UART_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int NB = 1 + DB + PB + SB;
    localparam int NLB = 103;

    logic clk = 1'b0;
    logic i_reset = 1'b1;
    logic [TB-1:0] div_in = 10'd16;
    logic rx_drv = 1'b1;
    logic loop = 1'b0;
    logic rx_line;
    logic o_tx, o_tx_ready, o_rx_valid, o_rx_frame_err, o_rx_parity_err, o_rx_overrun;
    logic [DB-1:0] i_tx_data = '0;
    logic [DB-1:0] o_rx_data;
    logic i_tx_valid = 1'b0;
    logic i_rx_ready = 1'b1;

    always #5 clk = ~clk;
    assign rx_line = loop ? o_tx : rx_drv;

    uart_core #(.DATA_BITS(DB), .STOP_BITS(SB), .TIMER_BITS(TB), .PARITY_ODD(0)) dut (
        .clk(clk), .i_reset(i_reset), .i_clks_per_baud(div_in), .i_rx(rx_line), .o_tx(o_tx),
        .i_tx_data(i_tx_data), .i_tx_valid(i_tx_valid), .o_tx_ready(o_tx_ready),
        .o_rx_data(o_rx_data), .o_rx_valid(o_rx_valid), .i_rx_ready(i_rx_ready),
        .o_rx_frame_err(o_rx_frame_err), .o_rx_parity_err(o_rx_parity_err),
        .o_rx_overrun(o_rx_overrun)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [DB-1:0] data;
        logic ferr;
        logic perr;
    } rx_exp_t;

    typedef struct {
        logic [DB-1:0] data;
        int div;
        logic stop_hi;
        logic par;
        logic ferr;
    } vec_t;

    rx_exp_t exp_q[$];
    int rx_seen = 0;
    int ovr_cnt = 0;

    always @(negedge clk) begin
        rx_exp_t e;
        if (!i_reset) begin
            if (o_rx_overrun) ovr_cnt++;
            if (o_rx_valid && i_rx_ready) begin
                rx_seen++;
                check("rx_expected_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("rx_data", o_rx_data, e.data);
                    check("rx_frame_err", o_rx_frame_err, e.ferr);
                    check("rx_parity_err", o_rx_parity_err, e.perr);
                end
            end
        end
    end

    function automatic logic par_of(input logic [DB-1:0] d);
        return 1'($countones(d) % 2);
    endfunction

    // expected line level for frame bit i: start, data LSB first, optional parity, stop
    function automatic logic tx_bit(input logic [DB-1:0] d, input logic par, input int i);
        if (i == 0) return 1'b0;
        if (i <= DB) return d[i-1];
        if (PB == 1 && i == DB + 1) return par;
        return 1'b1;
    endfunction

    task automatic tx_frame(input logic [DB-1:0] d, input int dv, input logic par, input logic fresh,
                            input logic nxt, input logic [DB-1:0] nd, input int ndv);
        int bad_w = 0;
        int bad_r = 0;
        if (fresh) begin
            @(negedge clk);
            check("tx_ready_before", o_tx_ready, 1);
            i_tx_data = d;
            div_in = 10'(dv);
            i_tx_valid = 1'b1;
        end
        for (int j = 0; j < NB * dv; j++) begin
            @(negedge clk);
            if (j == 0) i_tx_valid = 1'b0;
            if (j == dv) div_in = 10'($urandom_range(4, 1023));
            if (o_tx !== tx_bit(d, par, j / dv)) bad_w++;
            if (o_tx_ready !== (j == NB * dv - 1)) bad_r++;
        end
        check("tx_wave_bad_cycles", bad_w, 0);
        check("tx_ready_bad_cycles", bad_r, 0);
        if (nxt) begin
            i_tx_data = nd;
            div_in = 10'(ndv);
            i_tx_valid = 1'b1;
        end else begin
            @(negedge clk);
            check("tx_idle_after", {o_tx, o_tx_ready}, 2'b11);
        end
    endtask

    task automatic rx_drive(input logic [DB-1:0] d, input int dv, input logic stop_hi, input logic pflip);
        @(negedge clk);
        div_in = 10'(dv);
        for (int b = 0; b < 2 + DB + PB; b++) begin
            logic v;
            v = (b == 0) ? 1'b0 : (b <= DB) ? d[b-1] : (PB == 1 && b == DB + 1) ? (^d ^ pflip) : stop_hi;
            rx_drv = v;
            repeat (dv) @(negedge clk);
        end
        rx_drv = 1'b1;
    endtask

    task automatic wait_rx(input int target, input int budget);
        int n = 0;
        while (rx_seen < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("rx_arrived", rx_seen >= target, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vt[8];
        logic [DB-1:0] lb[NLB];
        int ldv[NLB];
        int base, ovr0;
        vt[0] = '{8'hA5, 16, 1'b1, 1'b0, 1'b0};
        vt[1] = '{8'h3C, 16, 1'b1, 1'b0, 1'b0};
        vt[2] = '{8'h55, 5, 1'b1, 1'b0, 1'b0};
        vt[3] = '{8'h00, 7, 1'b1, 1'b0, 1'b0};
        vt[4] = '{8'hFF, 23, 1'b1, 1'b0, 1'b0};
        vt[5] = '{8'h81, 4, 1'b1, 1'b0, 1'b0};
        vt[6] = '{8'h07, 16, 1'b1, 1'b1, 1'b0};
        vt[7] = '{8'hC3, 16, 1'b0, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        check("reset_tx", o_tx, 1);
        check("reset_tx_ready", o_tx_ready, 1);
        check("reset_rx_valid", o_rx_valid, 0);
        check("reset_rx_data", o_rx_data, 0);
        check("reset_frame_err", o_rx_frame_err, 0);
        check("reset_parity_err", o_rx_parity_err, 0);
        check("reset_overrun", o_rx_overrun, 0);
        i_reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            tx_frame(vt[v].data, vt[v].div, vt[v].par, 1'b1, 1'b0, '0, 0);
            exp_q.push_back('{data: vt[v].data, ferr: vt[v].ferr, perr: 1'b0});
            base = rx_seen;
            rx_drive(vt[v].data, vt[v].div, vt[v].stop_hi, 1'b0);
            wait_rx(base + 1, 4 * vt[v].div);
            repeat (4) @(negedge clk);
        end

        // backpressure: first byte held, second dropped with one overrun pulse
        i_rx_ready = 1'b0;
        exp_q.push_back('{data: 8'h3C, ferr: 1'b0, perr: 1'b0});
        rx_drive(8'h3C, 16, 1'b1, 1'b0);
        repeat (8) @(negedge clk);
        check("bp_valid_held", o_rx_valid, 1);
        check("bp_data_held", o_rx_data, 8'h3C);
        ovr0 = ovr_cnt;
        rx_drive(8'h55, 16, 1'b1, 1'b0);
        repeat (8) @(negedge clk);
        check("bp_overrun_pulses", ovr_cnt - ovr0, 1);
        check("bp_data_kept", o_rx_data, 8'h3C);
        check("bp_valid_kept", o_rx_valid, 1);
        @(posedge clk);
        #1 i_rx_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_valid_cleared", o_rx_valid, 0);
        check("bp_queue_drained", exp_q.size(), 0);

        // start-bit glitch: 4 low clocks produce nothing
        base = rx_seen;
        @(negedge clk);
        div_in = 10'd16;
        rx_drv = 1'b0;
        repeat (4) @(negedge clk);
        rx_drv = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_no_byte", rx_seen - base, 0);
        check("glitch_valid_low", o_rx_valid, 0);

`ifdef UART_PARITY_EN
        exp_q.push_back('{data: 8'h07, ferr: 1'b0, perr: 1'b1});
        base = rx_seen;
        rx_drive(8'h07, 16, 1'b1, 1'b1);
        wait_rx(base + 1, 64);
`endif

        // reset during data bit 3 of 0x52 (that bit is 0)
        @(negedge clk);
        i_tx_data = 8'h52;
        div_in = 10'd16;
        i_tx_valid = 1'b1;
        @(negedge clk);
        i_tx_valid = 1'b0;
        repeat (70) @(negedge clk);
        check("mid_tx_bit3_low", o_tx, 0);
        i_reset = 1'b1;
        @(negedge clk);
        check("mid_reset_tx_high", o_tx, 1);
        check("mid_reset_ready", o_tx_ready, 1);
        i_reset = 1'b0;
        tx_frame(8'h52, 16, 1'b1, 1'b1, 1'b0, '0, 0);

        tx_frame(8'h96, 8, 1'b0, 1'b1, 1'b1, 8'h3B, 12);
        tx_frame(8'h3B, 12, 1'b1, 1'b0, 1'b0, '0, 0);

        // random loopback, back-to-back frames with per-frame divisors
        repeat (4) @(negedge clk);
        loop = 1'b1;
        i_rx_ready = 1'b1;
        for (int k = 0; k < NLB; k++) begin
            lb[k] = 8'($urandom);
            ldv[k] = (k < 3) ? 868 : int'($urandom_range(6, 20));
        end
        base = rx_seen;
        for (int k = 0; k < NLB; k++) begin
            exp_q.push_back('{data: lb[k], ferr: 1'b0, perr: 1'b0});
            tx_frame(lb[k], ldv[k], par_of(lb[k]), k == 0, k < NLB - 1,
                     (k < NLB - 1) ? lb[k+1] : '0, (k < NLB - 1) ? ldv[k+1] : 0);
        end
        wait_rx(base + NLB, 200);
        check("loop_count", rx_seen - base, NLB);
        check("loop_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
